// File: rtl/cnt_bcd_display.sv
// Binary-to-BCD converter (sequential double-dabble, 9-cycle period) driving a
// 3-digit multiplexed 7-segment display with leading-zero blanking.
module cnt_bcd_display #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter bit          COMMON_ANODE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  cnt,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_RST = COMMON_ANODE ? 7'b1000000 : 7'b0111111;
  localparam logic [2:0] AN_RST  = COMMON_ANODE ? 3'b110 : 3'b001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [18:0]   shreg_q, shreg_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [11:0]   bcd_q, bcd_d;
  logic          valid_q, valid_d;
  logic [18:0]   adj;

  logic [RW-1:0] ref_q, ref_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    glyph;
  logic [2:0]    an_oh;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    bcd_d    = bcd_q;
    valid_d  = 1'b0;
    adj      = shreg_q;
    case (state_q)
      S_IDLE: begin
        shreg_d  = {12'b0, cnt};
        bitcnt_d = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        for (int unsigned i = 0; i < 3; i++) begin
          if (adj[7 + 4*i +: 4] >= 4'd5)
            adj[7 + 4*i +: 4] = adj[7 + 4*i +: 4] + 4'd3;
        end
        shreg_d  = {adj[17:0], 1'b0};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd6)
          state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = shreg_q[18:7];
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Display path looks ahead at the next index so an/seg switch on the same edge as the index.
  always_comb begin
    ref_d = (ref_q == REF_LAST) ? '0 : ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == REF_LAST)
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    nib   = '0;
    blank = 1'b1;
    case (idx_d)
      2'd0: begin
        nib   = bcd_q[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        nib   = bcd_q[7:4];
        blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        nib   = bcd_q[11:8];
        blank = (bcd_q[11:8] == 4'd0);
      end
      default: begin
        nib   = '0;
        blank = 1'b1;
      end
    endcase
    glyph = blank ? 7'h00 : decode(nib);
    seg_d = COMMON_ANODE ? ~glyph : glyph;
    an_oh = 3'b001 << idx_d;
    an_d  = COMMON_ANODE ? ~an_oh : an_oh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      bcd_q    <= '0;
      valid_q  <= 1'b0;
      ref_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_RST;
      an_q     <= AN_RST;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      bcd_q    <= bcd_d;
      valid_q  <= valid_d;
      ref_q    <= ref_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = valid_q;
  assign busy      = (state_q != S_IDLE);
  assign seg       = seg_q;
  assign an        = an_q;

endmodule

// File: tb/tb_cnt_bcd_display.sv
// Scoreboard bench for cnt_bcd_display (COMMON_ANODE=1, REFRESH_DIV=4).
module tb_cnt_bcd_display;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  cnt = '0;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic [6:0]  seg;
  logic [2:0]  an;

  cnt_bcd_display #(
    .REFRESH_DIV (DIV),
    .COMMON_ANODE(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (cnt),
    .bcd      (bcd),
    .bcd_valid(bcd_valid),
    .busy     (busy),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned n     = 0;
  logic [11:0] exp_q[$];
  logic [11:0] cur_exp  = '0;
  logic [11:0] prev_exp = '0;
  logic [6:0]  tbl[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int unsigned v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [6:0] seg_model(input int unsigned pos, input logic [11:0] b);
    int unsigned h, t, o, d;
    logic        blk;
    h = 32'(b[11:8]);
    t = 32'(b[7:4]);
    o = 32'(b[3:0]);
    d = (pos == 0) ? o : (pos == 1) ? t : h;
    blk = (pos == 2 && h == 0) || (pos == 1 && h == 0 && t == 0);
    return blk ? 7'h7F : ~tbl[d];
  endfunction

  function automatic logic [2:0] an_model(input int unsigned pos);
    logic [2:0] oh;
    oh = 3'b001 << pos;
    return ~oh;
  endfunction

  // Reference: a fresh sample of cnt is taken every 9th edge after reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      exp_q.delete();
    end else begin
      if (n % 9 == 0)
        exp_q.push_back(to_bcd(32'(cnt)));
      n++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_exp  = '0;
      prev_exp = '0;
    end
    check("seg", 32'(seg), 32'(seg_model((n / DIV) % 3, prev_exp)));
    check("an", 32'(an), 32'(an_model((n / DIV) % 3)));
    check("busy", 32'(busy), 32'(n % 9 != 0));
    check("bcd_valid", 32'(bcd_valid), 32'(n > 0 && n % 9 == 0));
    if (bcd_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: bcd_valid with empty queue, bcd=%03h at %0t", bcd, $time);
      end else begin
        cur_exp = exp_q.pop_front();
      end
    end
    check("bcd", 32'(bcd), 32'(cur_exp));
    prev_exp = cur_exp;
  end

  task automatic hold(input logic [6:0] v, input int unsigned cycles);
    cnt = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cnt   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(7'd0, 20);
    hold(7'd100, 40);
    hold(7'd127, 20);
    hold(7'd99, 30);
    hold(7'd7, 30);

    hold(7'd5, 18);
    for (int i = 0; i < 20 && (n % 9) != 3; i++) begin
      @(posedge clk);
      #1;
    end
    check("sync_shift", 32'(n % 9), 32'd3);
    hold(7'd42, 30);

    hold(7'd77, 5);
    rst_n = 1'b0;
    #1;
    check("rst_bcd", 32'(bcd), 32'h000);
    check("rst_valid", 32'(bcd_valid), 32'd0);
    check("rst_an", 32'(an), 32'(3'b110));
    check("rst_seg", 32'(seg), 32'(7'b1000000));
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_bcd", 32'(bcd), 32'h000);
    rst_n = 1'b1;

    for (int i = 0; i < 150; i++)
      hold(7'($urandom_range(0, 127)), $urandom_range(1, 14));
    hold(7'd64, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
